// File: rtl/pusch_iq_framer.sv
`default_nettype none
// pusch_iq_framer: scales 26-bit I/Q to 16 bits with rounding and saturation,
// tags symbol/slot boundaries, and buffers samples in a show-ahead FIFO.
module pusch_iq_framer #(
  parameter int IN_WIDTH     = 26,
  parameter int OUT_WIDTH    = 16,
  parameter int SHIFT        = 10,
  parameter int FIFO_DEPTH   = 16,
  parameter int NFFT         = 2048,
  parameter int CP_LEN0      = 160,
  parameter int CP_LEN       = 144,
  parameter int SYM_PER_SLOT = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IN_WIDTH-1:0]    in_r,
  input  logic [IN_WIDTH-1:0]    in_i,
  input  logic                   in_valid,
  output logic [2*OUT_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sos,
  output logic                   out_eos,
  output logic [3:0]             sym_idx,
  output logic                   overflow,
  output logic                   sat_flag
);

  localparam int LEN0 = CP_LEN0 + NFFT;
  localparam int LEN  = CP_LEN + NFFT;
  localparam int LMAX = (LEN0 > LEN) ? LEN0 : LEN;
  localparam int SCW  = $clog2(LMAX);
  localparam int XW   = IN_WIDTH + 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int EW   = 2*OUT_WIDTH + 6;

  localparam logic signed [XW-1:0] RND     = XW'(2**(SHIFT-1));
  localparam logic signed [XW-1:0] SAT_MAX = XW'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

  // Returns {saturated, value}
  function automatic logic [OUT_WIDTH:0] scale(input logic [IN_WIDTH-1:0] x);
    logic signed [XW-1:0] sum;
    logic signed [XW-1:0] sh;
    sum = $signed({x[IN_WIDTH-1], x}) + RND;
    sh  = sum >>> SHIFT;
    if (sh > SAT_MAX)
      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (sh < SAT_MIN)
      return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    else
      return {1'b0, sh[OUT_WIDTH-1:0]};
  endfunction

  logic [SCW-1:0]   samp_cnt;
  logic [3:0]       sym_cnt;
  logic             sym_long;
  logic             samp_last;
  logic             sym_last;
  logic [OUT_WIDTH:0] sc_r;
  logic [OUT_WIDTH:0] sc_i;

  assign sym_long  = (sym_cnt == 4'd0) || (sym_cnt == 4'(SYM_PER_SLOT/2));
  assign samp_last = (samp_cnt == (sym_long ? SCW'(LEN0-1) : SCW'(LEN-1)));
  assign sym_last  = (sym_cnt == 4'(SYM_PER_SLOT-1));
  assign sc_r      = scale(in_r);
  assign sc_i      = scale(in_i);

  // Framing counters run on every input sample, even ones later dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      samp_cnt <= '0;
      sym_cnt  <= '0;
    end else if (in_valid) begin
      if (samp_last) begin
        samp_cnt <= '0;
        sym_cnt  <= sym_last ? 4'd0 : sym_cnt + 4'd1;
      end else begin
        samp_cnt <= samp_cnt + SCW'(1);
      end
    end
  end

  logic          s1_valid;
  logic [EW-1:0] s1_entry;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid && (sc_r[OUT_WIDTH] || sc_i[OUT_WIDTH]))
        sat_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid)
      s1_entry <= {sc_r[OUT_WIDTH-1:0], sc_i[OUT_WIDTH-1:0],
                   (samp_cnt == '0), (sym_last && samp_last), sym_cnt};
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          do_read;
  logic          do_write;
  logic [EW-1:0] head;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign do_read   = out_valid && out_ready;
  assign do_write  = s1_valid && (!full || do_read);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_ptr] <= s1_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_read)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_write && !do_read)
        count <= count + CW'(1);
      else if (!do_write && do_read)
        count <= count - CW'(1);
      if (s1_valid && full && !do_read)
        overflow <= 1'b1;
    end
  end

  // Gate the head so outputs read zero when the FIFO is empty
  assign out_data = out_valid ? head[EW-1:6] : '0;
  assign out_sos  = out_valid && head[5];
  assign out_eos  = out_valid && head[4];
  assign sym_idx  = out_valid ? head[3:0] : 4'd0;

endmodule
`default_nettype wire
